key_event_decoder: RTL and testbench
====================================

// Module: key_event_decoder
// PURPOSE
//  Consumes the debounced strobe/level pair produced by the key debouncer
//  (key_flag, key_value) and classifies each key gesture into one-cycle event
//  pulses: short press, double click, long press and auto-repeat while held.
//  It sits between the debouncer and the snake direction/control logic.
// PARAMETERS
//  CNT_W       32          width of the internal interval counter
//  LONG_CNT    50_000_000  cycles held before long press (1 s @ 50 MHz)
//  DCLICK_CNT  15_000_000  max release-to-second-press gap (300 ms)
//  REPEAT_CNT  10_000_000  auto-repeat period while long-held (200 ms)
//  All three counts must be >= 2 and < 2**CNT_W.
// PORTS
//  key_clk       in   1  system clock, 50 MHz
//  key_rst_n     in   1  reset, synchronous, active-low
//  key_flag      in   1  one-cycle strobe: debounced level is valid/updated
//  key_value     in   1  debounced key level, 0 = pressed, 1 = released
//  short_press   out  1  one-cycle pulse: single short click confirmed
//  double_click  out  1  one-cycle pulse: second press inside DCLICK window
//  long_press    out  1  one-cycle pulse: key held LONG_CNT cycles
//  repeat_pulse  out  1  one-cycle pulse every REPEAT_CNT cycles after long
//  key_held      out  1  level: 1 while tracked debounced state is pressed
// BEHAVIOUR
//  - Reset: state IDLE, counter 0, pressed_q 0, every output 0. Reset taken
//    mid-gesture discards it; no pulse emitted for the aborted gesture.
//  - Events: PRESS = key_flag & ~key_value & ~pressed_q;
//    RELEASE = key_flag & key_value & pressed_q. A strobe whose level equals
//    pressed_q (bounce that settled back) is a no-op. key_held = pressed_q.
//  - Counter clears on every state entry, increments once per cycle in
//    PRESS1/WAIT2/LONG; it never wraps (always reset before terminal+1).
//  - All outputs registered; every pulse asserts exactly 1 cycle, 1 cycle
//    after the triggering event or terminal count.
//  - FSM:
//    IDLE  : PRESS -> PRESS1.
//    PRESS1: RELEASE -> WAIT2; else cnt==LONG_CNT-1 -> LONG, long_press.
//    WAIT2 : PRESS -> PRESS2, double_click;
//            else cnt==DCLICK_CNT-1 -> IDLE, short_press.
//    PRESS2: RELEASE -> IDLE; no long detection; no further pulses.
//    LONG  : RELEASE -> IDLE (no short_press); else cnt==REPEAT_CNT-1 ->
//            repeat_pulse, cnt cleared, stay LONG.
//  - Simultaneous event and terminal count in the same cycle: event wins
//    (release at LONG_CNT-1 is a short path; press at DCLICK_CNT-1 is a
//    double click). At most one output pulse per cycle.
//  - Hold after double click yields no long_press/repeat until next gesture.
// TESTING  (bench params: LONG_CNT=20, DCLICK_CNT=10, REPEAT_CNT=5)
//  1. PRESS at T, RELEASE at T+5, idle -> short_press single pulse at
//     T+5+10+1 region (exactly DCLICK_CNT cycles after WAIT2 entry, +1);
//     no other pulses; key_held high T+1..T+5.
//  2. PRESS, RELEASE 5 cycles later, PRESS 4 cycles after that ->
//     double_click 1 cycle after second strobe; short_press never asserts.
//  3. PRESS at T, hold 40 cycles -> long_press at T+21; repeat_pulse at
//     T+26, T+31, T+36; RELEASE -> no short_press, key_held drops.
//  4. key_flag with key_value=1 while IDLE, and key_flag with key_value=0
//     while already pressed -> no pulse, state and key_held unchanged.
//  5. RELEASE landing on the LONG_CNT-1 cycle -> no long_press; short_press
//     after DCLICK window. Repeat with PRESS on DCLICK_CNT-1 -> double_click.
//  6. key_rst_n low for 1 cycle during LONG -> all outputs 0 next cycle;
//     following RELEASE strobe is a no-op; next PRESS starts fresh from IDLE.

Source files
------------

// File: rtl/key_event_decoder_if.sv
// Key event bus: debounced strobe/level from the debouncer into the decoder,
// classified gesture pulses and the held level back out to the control logic.
interface key_event_decoder_if;
  logic key_flag;
  logic key_value;
  logic short_press;
  logic double_click;
  logic long_press;
  logic repeat_pulse;
  logic key_held;

  // Debouncer side: drives the strobe/level pair, observes the events.
  modport master (
    output key_flag,
    output key_value,
    input  short_press,
    input  double_click,
    input  long_press,
    input  repeat_pulse,
    input  key_held
  );

  // Decoder side.
  modport slave (
    input  key_flag,
    input  key_value,
    output short_press,
    output double_click,
    output long_press,
    output repeat_pulse,
    output key_held
  );
endinterface

// File: rtl/key_event_decoder.sv
// Key gesture classifier: turns the debounced key strobe/level into one-cycle
// short press, double click, long press and auto-repeat pulses, plus a held
// level. All outputs are registered; at most one pulse per cycle.
module key_event_decoder #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned LONG_CNT   = 50_000_000,
  parameter int unsigned DCLICK_CNT = 15_000_000,
  parameter int unsigned REPEAT_CNT = 10_000_000
) (
  input  logic                 key_clk,
  input  logic                 key_rst_n,
  key_event_decoder_if.slave   key_bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_WAIT2  = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_LONG   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] DCLICK_TERM = CNT_W'(DCLICK_CNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CNT - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             cnt_clr;
  logic             cnt_run;
  logic             pressed_q;
  logic             press_ev;
  logic             release_ev;

  logic             short_next;
  logic             double_next;
  logic             long_next;
  logic             repeat_next;

  logic             short_q;
  logic             double_q;
  logic             long_q;
  logic             repeat_q;

  // A strobe only counts when it changes the tracked level; a strobe that
  // repeats the current level is a settled bounce and is ignored.
  assign press_ev   = key_bus.key_flag & ~key_bus.key_value & ~pressed_q;
  assign release_ev = key_bus.key_flag &  key_bus.key_value &  pressed_q;

  // Tracked debounced level.
  always_ff @(posedge key_clk) begin
    if (!key_rst_n) begin
      pressed_q <= 1'b0;
    end else if (press_ev) begin
      pressed_q <= 1'b1;
    end else if (release_ev) begin
      pressed_q <= 1'b0;
    end
  end

  // State and interval counter registers.
  always_ff @(posedge key_clk) begin
    if (!key_rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state, counter control and pulse decode; key events take priority
  // over terminal counts so at most one pulse is produced per cycle.
  always_comb begin
    state_next  = state;
    cnt_clr     = 1'b0;
    cnt_run     = 1'b0;
    short_next  = 1'b0;
    double_next = 1'b0;
    long_next   = 1'b0;
    repeat_next = 1'b0;

    case (state)
      ST_IDLE: begin
        if (press_ev) begin
          state_next = ST_PRESS1;
        end
      end

      ST_PRESS1: begin
        cnt_run = 1'b1;
        if (release_ev) begin
          state_next = ST_WAIT2;
        end else if (cnt == LONG_TERM) begin
          state_next = ST_LONG;
          long_next  = 1'b1;
        end
      end

      ST_WAIT2: begin
        cnt_run = 1'b1;
        if (press_ev) begin
          state_next  = ST_PRESS2;
          double_next = 1'b1;
        end else if (cnt == DCLICK_TERM) begin
          state_next = ST_IDLE;
          short_next = 1'b1;
        end
      end

      ST_PRESS2: begin
        if (release_ev) begin
          state_next = ST_IDLE;
        end
      end

      ST_LONG: begin
        cnt_run = 1'b1;
        if (release_ev) begin
          state_next = ST_IDLE;
        end else if (cnt == REPEAT_TERM) begin
          repeat_next = 1'b1;
          cnt_clr     = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (state_next != state) begin
      cnt_clr = 1'b1;
    end

    if (cnt_clr) begin
      cnt_next = '0;
    end else if (cnt_run) begin
      cnt_next = cnt + 1'b1;
    end else begin
      cnt_next = cnt;
    end
  end

  // Registered event pulses.
  always_ff @(posedge key_clk) begin
    if (!key_rst_n) begin
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
    end else begin
      short_q  <= short_next;
      double_q <= double_next;
      long_q   <= long_next;
      repeat_q <= repeat_next;
    end
  end

  assign key_bus.short_press  = short_q;
  assign key_bus.double_click = double_q;
  assign key_bus.long_press   = long_q;
  assign key_bus.repeat_pulse = repeat_q;
  assign key_bus.key_held     = pressed_q;

  // Structural invariants: one pulse at most, counter bounded by the active
  // state's terminal count, and the held level consistent with the state.
  a_one_pulse : assert property (@(posedge key_clk) disable iff (!key_rst_n)
    $onehot0({short_q, double_q, long_q, repeat_q}));

  a_cnt_press1 : assert property (@(posedge key_clk) disable iff (!key_rst_n)
    (state == ST_PRESS1) |-> (cnt <= LONG_TERM));

  a_cnt_wait2 : assert property (@(posedge key_clk) disable iff (!key_rst_n)
    (state == ST_WAIT2) |-> (cnt <= DCLICK_TERM));

  a_cnt_long : assert property (@(posedge key_clk) disable iff (!key_rst_n)
    (state == ST_LONG) |-> (cnt <= REPEAT_TERM));

  a_cnt_idle : assert property (@(posedge key_clk) disable iff (!key_rst_n)
    (state == ST_IDLE || state == ST_PRESS2) |-> (cnt == '0));

  a_held_state : assert property (@(posedge key_clk) disable iff (!key_rst_n)
    pressed_q == (state == ST_PRESS1 || state == ST_PRESS2 || state == ST_LONG));

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with short counts (LONG=20, DCLICK=10,
// REPEAT=5). Each cycle the full output vector {short, double, long, repeat,
// held} is compared with a hand-derived expectation.
module tb_key_event_decoder;

  logic clk;
  logic rst_n;
  int   vectors;
  int   errors;

  key_event_decoder_if bus ();

  key_event_decoder #(
    .CNT_W      (8),
    .LONG_CNT   (20),
    .DCLICK_CNT (10),
    .REPEAT_CNT (5)
  ) dut (
    .key_clk   (clk),
    .key_rst_n (rst_n),
    .key_bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Drive one cycle of inputs, advance past the edge, drop the strobe.
  // Outputs read afterwards belong to the cycle following the driven one.
  task automatic step(input logic flag, input logic value, input logic rst);
    bus.key_flag  = flag;
    bus.key_value = value;
    rst_n         = rst;
    @(posedge clk);
    #1;
    bus.key_flag = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    for (int c = 0; c < 2; c++) begin
      step(1'b0, 1'b1, 1'b0);
      obs = {bus.short_press, bus.double_click, bus.long_press, bus.repeat_pulse, bus.key_held};
      vectors++;
      if (obs !== 5'b00000) begin
        errors++;
        $display("FAIL reset c=%0d got=%b exp=%b", c, obs, 5'b00000);
      end
    end
    step(1'b0, 1'b1, 1'b1);
  endtask

  // Press at 0, release at 5: short_press at 5+10+1 = 16, held 1..5.
  task automatic test_short_press();
    logic [4:0] obs, exp;
    int t;
    for (int c = 0; c < 26; c++) begin
      if (c == 0)      step(1'b1, 1'b0, 1'b1);
      else if (c == 5) step(1'b1, 1'b1, 1'b1);
      else             step(1'b0, 1'b1, 1'b1);
      t   = c + 1;
      exp = {t == 16, 1'b0, 1'b0, 1'b0, (t >= 1 && t <= 5)};
      obs = {bus.short_press, bus.double_click, bus.long_press, bus.repeat_pulse, bus.key_held};
      vectors++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL short_press t=%0d got=%b exp=%b", t, obs, exp);
      end
    end
  endtask

  // Press 0, release 5, press 9, release 12: double_click at 10, no short.
  task automatic test_double_click();
    logic [4:0] obs, exp;
    int t;
    for (int c = 0; c < 30; c++) begin
      if (c == 0 || c == 9)       step(1'b1, 1'b0, 1'b1);
      else if (c == 5 || c == 12) step(1'b1, 1'b1, 1'b1);
      else                        step(1'b0, 1'b1, 1'b1);
      t   = c + 1;
      exp = {1'b0, t == 10, 1'b0, 1'b0, ((t >= 1 && t <= 5) || (t >= 10 && t <= 12))};
      obs = {bus.short_press, bus.double_click, bus.long_press, bus.repeat_pulse, bus.key_held};
      vectors++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL double_click t=%0d got=%b exp=%b", t, obs, exp);
      end
    end
  endtask

  // Press 0, release 40: long at 21, repeats at 26/31/36; the release lands
  // on the repeat terminal cycle so no repeat at 41 and no short afterwards.
  task automatic test_long_repeat();
    logic [4:0] obs, exp;
    int t;
    for (int c = 0; c < 60; c++) begin
      if (c == 0)       step(1'b1, 1'b0, 1'b1);
      else if (c == 40) step(1'b1, 1'b1, 1'b1);
      else              step(1'b0, 1'b1, 1'b1);
      t   = c + 1;
      exp = {1'b0, 1'b0, t == 21, (t == 26 || t == 31 || t == 36), (t >= 1 && t <= 40)};
      obs = {bus.short_press, bus.double_click, bus.long_press, bus.repeat_pulse, bus.key_held};
      vectors++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL long_repeat t=%0d got=%b exp=%b", t, obs, exp);
      end
    end
  endtask

  // Redundant strobes: released-level strobe in IDLE (c0), pressed-level
  // strobe while pressed (c5), released-level strobe in WAIT2 (c12).
  // Real press 2, release 8: short at 19, held 3..8.
  task automatic test_redundant_strobe();
    logic [4:0] obs, exp;
    int t;
    for (int c = 0; c < 25; c++) begin
      if (c == 0 || c == 8 || c == 12) step(1'b1, 1'b1, 1'b1);
      else if (c == 2 || c == 5)       step(1'b1, 1'b0, 1'b1);
      else                             step(1'b0, 1'b1, 1'b1);
      t   = c + 1;
      exp = {t == 19, 1'b0, 1'b0, 1'b0, (t >= 3 && t <= 8)};
      obs = {bus.short_press, bus.double_click, bus.long_press, bus.repeat_pulse, bus.key_held};
      vectors++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL redundant_strobe t=%0d got=%b exp=%b", t, obs, exp);
      end
    end
  endtask

  // Release on the long terminal cycle (c20): no long, short at 31.
  task automatic test_release_at_long_term();
    logic [4:0] obs, exp;
    int t;
    for (int c = 0; c < 35; c++) begin
      if (c == 0)       step(1'b1, 1'b0, 1'b1);
      else if (c == 20) step(1'b1, 1'b1, 1'b1);
      else              step(1'b0, 1'b1, 1'b1);
      t   = c + 1;
      exp = {t == 31, 1'b0, 1'b0, 1'b0, (t >= 1 && t <= 20)};
      obs = {bus.short_press, bus.double_click, bus.long_press, bus.repeat_pulse, bus.key_held};
      vectors++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL release_at_long_term t=%0d got=%b exp=%b", t, obs, exp);
      end
    end
  endtask

  // Press 0, release 3 (WAIT2 from 4), second press on the dclick terminal
  // cycle 13: double at 14, never a short. Release 16.
  task automatic test_press_at_dclick_term();
    logic [4:0] obs, exp;
    int t;
    for (int c = 0; c < 25; c++) begin
      if (c == 0 || c == 13)      step(1'b1, 1'b0, 1'b1);
      else if (c == 3 || c == 16) step(1'b1, 1'b1, 1'b1);
      else                        step(1'b0, 1'b1, 1'b1);
      t   = c + 1;
      exp = {1'b0, t == 14, 1'b0, 1'b0, ((t >= 1 && t <= 3) || (t >= 14 && t <= 16))};
      obs = {bus.short_press, bus.double_click, bus.long_press, bus.repeat_pulse, bus.key_held};
      vectors++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL press_at_dclick_term t=%0d got=%b exp=%b", t, obs, exp);
      end
    end
  endtask

  // Hold after a double click: press 0, release 3, press 6, hold to 40.
  // Only the double click at 7; no long or repeat.
  task automatic test_hold_after_double();
    logic [4:0] obs, exp;
    int t;
    for (int c = 0; c < 45; c++) begin
      if (c == 0 || c == 6)       step(1'b1, 1'b0, 1'b1);
      else if (c == 3 || c == 40) step(1'b1, 1'b1, 1'b1);
      else                        step(1'b0, 1'b1, 1'b1);
      t   = c + 1;
      exp = {1'b0, t == 7, 1'b0, 1'b0, ((t >= 1 && t <= 3) || (t >= 7 && t <= 40))};
      obs = {bus.short_press, bus.double_click, bus.long_press, bus.repeat_pulse, bus.key_held};
      vectors++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL hold_after_double t=%0d got=%b exp=%b", t, obs, exp);
      end
    end
  endtask

  // Reset during LONG at cycle 25 (would have repeated at 26): all zero at 26.
  // Release strobe at 28 is a no-op; fresh press at 30 gives long at 51;
  // release at 55 lands on the repeat terminal so nothing follows.
  task automatic test_reset_mid_long();
    logic [4:0] obs, exp;
    int t;
    for (int c = 0; c < 61; c++) begin
      if (c == 0 || c == 30)       step(1'b1, 1'b0, 1'b1);
      else if (c == 25)            step(1'b0, 1'b1, 1'b0);
      else if (c == 28 || c == 55) step(1'b1, 1'b1, 1'b1);
      else                         step(1'b0, 1'b1, 1'b1);
      t   = c + 1;
      exp = {1'b0, 1'b0, (t == 21 || t == 51), 1'b0,
             ((t >= 1 && t <= 25) || (t >= 31 && t <= 55))};
      obs = {bus.short_press, bus.double_click, bus.long_press, bus.repeat_pulse, bus.key_held};
      vectors++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_mid_long t=%0d got=%b exp=%b", t, obs, exp);
      end
    end
  endtask

  initial begin
    vectors       = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.key_flag  = 1'b0;
    bus.key_value = 1'b1;

    test_reset();
    test_short_press();
    test_double_click();
    test_long_repeat();
    test_redundant_strobe();
    test_release_at_long_term();
    test_press_at_dclick_term();
    test_hold_after_double();
    test_reset_mid_long();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
